// File: rtl/car_det_pkg.sv
// Shared types and constants for the car direction detector.
//   state_t      : direction FSM states
//   NONE/A_ONLY/B_ONLY/BOTH : filtered sensor codes, ordered {a,b}
package car_det_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENT_A,
    ENT_AB,
    ENT_B,
    EXT_B,
    EXT_AB,
    EXT_A,
    ABORT
  } state_t;

  localparam logic [1:0] NONE   = 2'b00;
  localparam logic [1:0] A_ONLY = 2'b10;
  localparam logic [1:0] B_ONLY = 2'b01;
  localparam logic [1:0] BOTH   = 2'b11;

  // True for the six states that belong to a car transit.
  function automatic logic is_transit(input state_t s);
    return (s != IDLE) && (s != ABORT);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Synchronizer plus optional glitch filter for one asynchronous gate sensor.
// Ports: clk, rst (sync, active-high), din (raw async sensor), dout (clean bit).
// Optional filter enabled by defining CAR_DET_DEBOUNCE_EN.
module sensor_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  // Reject out-of-range configurations at elaboration.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3 || DEBOUNCE_CYCLES == 0) begin : g_param_check
    $error("sensor_debounce: illegal SYNC_STAGES or DEBOUNCE_CYCLES");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;

  // Metastability chain.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef CAR_DET_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          filt_q;

  // Follow the synchronized bit only after it differs for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else if (sync_out != filt_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        filt_q <= sync_out;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign dout = filt_q;
`else
  assign dout = sync_out;
`endif

endmodule

// File: rtl/car_direction_detector.sv
// Gate direction detector: turns the outer (A) / inner (B) photo-sensor pair
// into single-cycle enter / exit pulses for the parking-lot counter.
// Ports: clk, rst (sync, active-high), sensor_a, sensor_b (raw async, 1=blocked),
//        enter, exit, error (registered one-cycle pulses), busy (registered, FSM not idle).
// Optional sensor glitch filter: define CAR_DET_DEBOUNCE_EN.
module car_direction_detector
  import car_det_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor_a,
  input  logic sensor_b,
  output logic enter,
  output logic exit,
  output logic error,
  output logic busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          fa, fb;
  logic [1:0]    code;
  state_t        state_q, state_d;
  logic [TW-1:0] tcnt_q;
  logic          enter_d, exit_d, error_d, busy_d;
  logic          timeout;

  sensor_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk (clk), .rst (rst), .din (sensor_a), .dout (fa)
  );

  sensor_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk (clk), .rst (rst), .din (sensor_b), .dout (fb)
  );

  assign code    = {fa, fb};
  assign timeout = is_transit(state_q) && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      enter   <= 1'b0;
      exit    <= 1'b0;
      error   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      enter   <= enter_d;
      exit    <= exit_d;
      error   <= error_d;
      busy    <= busy_d;
    end
  end

  // Dwell counter: restarts on every state change, counts only inside a transit.
  always_ff @(posedge clk) begin
    if (rst)                                             tcnt_q <= '0;
    else if (state_d != state_q || !is_transit(state_q)) tcnt_q <= '0;
    else if (tcnt_q != TW'(TIMEOUT_CYCLES))              tcnt_q <= tcnt_q + TW'(1);
  end

  // Next-state and pulse decode.
  always_comb begin
    state_d = state_q;
    enter_d = 1'b0;
    exit_d  = 1'b0;
    error_d = 1'b0;

    case (state_q)
      IDLE: begin
        case (code)
          A_ONLY:  state_d = ENT_A;
          B_ONLY:  state_d = EXT_B;
          BOTH:    begin state_d = ABORT; error_d = 1'b1; end
          default: state_d = IDLE;
        endcase
      end
      ENT_A: begin
        case (code)
          A_ONLY:  state_d = ENT_A;
          BOTH:    state_d = ENT_AB;
          NONE:    state_d = IDLE;
          default: begin state_d = ABORT; error_d = 1'b1; end
        endcase
      end
      ENT_AB: begin
        case (code)
          BOTH:    state_d = ENT_AB;
          B_ONLY:  state_d = ENT_B;
          A_ONLY:  state_d = ENT_A;
          default: begin state_d = ABORT; error_d = 1'b1; end
        endcase
      end
      ENT_B: begin
        case (code)
          B_ONLY:  state_d = ENT_B;
          NONE:    begin state_d = IDLE; enter_d = 1'b1; end
          BOTH:    state_d = ENT_AB;
          default: begin state_d = ABORT; error_d = 1'b1; end
        endcase
      end
      EXT_B: begin
        case (code)
          B_ONLY:  state_d = EXT_B;
          BOTH:    state_d = EXT_AB;
          NONE:    state_d = IDLE;
          default: begin state_d = ABORT; error_d = 1'b1; end
        endcase
      end
      EXT_AB: begin
        case (code)
          BOTH:    state_d = EXT_AB;
          A_ONLY:  state_d = EXT_A;
          B_ONLY:  state_d = EXT_B;
          default: begin state_d = ABORT; error_d = 1'b1; end
        endcase
      end
      EXT_A: begin
        case (code)
          A_ONLY:  state_d = EXT_A;
          NONE:    begin state_d = IDLE; exit_d = 1'b1; end
          BOTH:    state_d = EXT_AB;
          default: begin state_d = ABORT; error_d = 1'b1; end
        endcase
      end
      ABORT: begin
        if (code == NONE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A stalled transit is aborted; a legal move on the same cycle wins.
    if (timeout && state_d == state_q) begin
      state_d = ABORT;
      error_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_car_direction_detector.sv
// Self-checking bench for car_direction_detector: directed gate scenarios with
// literal expectations plus randomized traffic, all checked every cycle against
// a path-walking behavioural model of the gate.
module tb_car_direction_detector;

  localparam int unsigned S = 2;
  localparam int unsigned T = 8;
  localparam int unsigned D = 4;
`ifdef CAR_DET_DEBOUNCE_EN
  localparam int LAT = S + D;
`else
  localparam int LAT = S;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sensor_a = 1'b0;
  logic sensor_b = 1'b0;
  logic enter, exit_o, error_o, busy;

  always #5 clk = ~clk;

  car_direction_detector #(
    .SYNC_STAGES(S), .TIMEOUT_CYCLES(T), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk (clk), .rst (rst), .sensor_a (sensor_a), .sensor_b (sensor_b),
    .enter (enter), .exit (exit_o), .error (error_o), .busy (busy)
  );

  int total = 0;
  int bad   = 0;

  // Model: a transit is a walk along the path 00 -> first -> 11 -> second -> 00.
  logic [1:0] dq[$];
  int   n_edge = 0;
  int   m_dir = 0;        // 0 none, 1 entry, 2 exit
  int   m_step = 0;       // position on the path, 0 = idle
  bit   m_abort = 1'b0;
  int   entered_edge = 0;
  logic e_enter = 1'b0, e_exit = 1'b0, e_err = 1'b0, e_busy = 1'b0;
  logic [1:0] filt = 2'b00, prev_y = 2'b00;
  int   run[2];

  // Pulse bookkeeping taken from the DUT, used by literal checks.
  int step_idx = 0;
  int n_ent = 0, n_ext = 0, n_err = 0, n_busy = 0;
  int last_ent = 0, last_err = 0;

  function automatic logic [1:0] path_code(input int dir, input int idx);
    if (idx == 0 || idx == 4) return 2'b00;
    if (idx == 2)             return 2'b11;
    if (dir == 1)             return (idx == 1) ? 2'b10 : 2'b01;
    return (idx == 1) ? 2'b01 : 2'b10;
  endfunction

  task automatic goto_abort();
    m_abort = 1'b1; m_step = 0; m_dir = 0; e_err = 1'b1; entered_edge = n_edge;
  endtask

  task automatic model_edge(input logic [1:0] raw, input logic r);
    logic [1:0] y, c;
    n_edge++;
    e_enter = 1'b0; e_exit = 1'b0; e_err = 1'b0;
    if (r) begin
      dq.delete();
      for (int i = 0; i < int'(S); i++) dq.push_back(2'b00);
      m_dir = 0; m_step = 0; m_abort = 1'b0; e_busy = 1'b0;
      filt = 2'b00; prev_y = 2'b00; run[0] = 0; run[1] = 0;
      return;
    end
    y = dq.pop_front();
    dq.push_back(raw);
`ifdef CAR_DET_DEBOUNCE_EN
    c = filt;
    for (int b = 0; b < 2; b++) begin
      if (y[b] == prev_y[b]) run[b]++; else run[b] = 1;
      prev_y[b] = y[b];
      if (run[b] >= int'(D)) filt[b] = y[b];
    end
`else
    c = y;
`endif
    if (m_abort) begin
      if (c == 2'b00) begin m_abort = 1'b0; entered_edge = n_edge; end
    end else if (m_step == 0) begin
      if (c == 2'b10)      begin m_dir = 1; m_step = 1; entered_edge = n_edge; end
      else if (c == 2'b01) begin m_dir = 2; m_step = 1; entered_edge = n_edge; end
      else if (c == 2'b11) goto_abort();
    end else if (c == path_code(m_dir, m_step)) begin
      if (n_edge - entered_edge == int'(T)) goto_abort();
    end else if (c == path_code(m_dir, m_step + 1)) begin
      m_step++; entered_edge = n_edge;
      if (m_step == 4) begin
        if (m_dir == 1) e_enter = 1'b1; else e_exit = 1'b1;
        m_step = 0; m_dir = 0;
      end
    end else if (c == path_code(m_dir, m_step - 1)) begin
      m_step--; entered_edge = n_edge;
      if (m_step == 0) m_dir = 0;
    end else begin
      goto_abort();
    end
    e_busy = m_abort || (m_step != 0);
  endtask

  // One clock: drive at negedge, advance model at posedge, compare at next negedge.
  task automatic step(input logic a, input logic b, input logic r);
    sensor_a = a; sensor_b = b; rst = r;
    @(posedge clk);
    model_edge({a, b}, r);
    @(negedge clk);
    step_idx++;
    total++;
    if ({enter, exit_o, error_o, busy} !== {e_enter, e_exit, e_err, e_busy}) begin
      bad++;
      $display("FAIL outputs step %0d: enter/exit/error/busy=%b%b%b%b required %b%b%b%b",
               step_idx, enter, exit_o, error_o, busy, e_enter, e_exit, e_err, e_busy);
    end
    if (enter === 1'b1)   begin n_ent++; last_ent = step_idx; end
    if (exit_o === 1'b1)  n_ext++;
    if (error_o === 1'b1) begin n_err++; last_err = step_idx; end
    if (busy === 1'b1)    n_busy++;
  endtask

  task automatic hold(input logic a, input logic b, input int len);
    repeat (len) step(a, b, 1'b0);
  endtask

  task automatic clear_counts();
    n_ent = 0; n_ext = 0; n_err = 0; n_busy = 0;
  endtask

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic random_car();
    int dir;
    logic [1:0] c;
    dir = int'($urandom_range(1, 2));
    for (int i = 1; i <= 4; i++) begin
      c = path_code(dir, i);
      if (i == 2 && $urandom_range(0, 4) == 0) begin
        c = path_code(dir, 1);
        hold(c[1], c[0], int'($urandom_range(1, 6)));
        c = path_code(dir, 2);
      end
      hold(c[1], c[0], int'($urandom_range(1, 10)));
    end
  endtask

  int mark;

  initial begin
    @(negedge clk);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("reset_outputs", int'({enter, exit_o, error_o, busy}), 0);
    hold(1'b0, 1'b0, 4);

    // Entry with exact latency on the completion pulse.
    clear_counts();
    hold(1'b1, 1'b0, 5); hold(1'b1, 1'b1, 5);
    check("entry_busy_mid", int'(busy), 1);
    hold(1'b0, 1'b1, 5);
    mark = step_idx + 1;
    hold(1'b0, 1'b0, 10);
    check("entry_enter_count", n_ent, 1);
    check("entry_exit_count", n_ext, 0);
    check("entry_error_count", n_err, 0);
    check("entry_latency", last_ent - mark, LAT);
    check("entry_busy_end", int'(busy), 0);

    // Exit.
    clear_counts();
    hold(1'b0, 1'b1, 5); hold(1'b1, 1'b1, 5); hold(1'b1, 1'b0, 5); hold(1'b0, 1'b0, 10);
    check("exit_exit_count", n_ext, 1);
    check("exit_enter_count", n_ent, 0);

    // Pedestrian.
    clear_counts();
    hold(1'b1, 1'b0, 5); hold(1'b0, 1'b0, 10);
    check("ped_pulses", n_ent + n_ext + n_err, 0);
    check("ped_busy_end", int'(busy), 0);

    // Back-out.
    clear_counts();
    hold(1'b1, 1'b0, 5); hold(1'b1, 1'b1, 5); hold(1'b1, 1'b0, 5); hold(1'b0, 1'b0, 10);
    check("backout_enter", n_ent, 0);
    check("backout_error", n_err, 0);

    // Illegal jump 00 -> 11.
    clear_counts();
    hold(1'b1, 1'b1, 8);
    check("illegal_error", n_err, 1);
    check("illegal_busy_held", int'(busy), 1);
    hold(1'b0, 1'b0, 10);
    check("illegal_busy_end", int'(busy), 0);
    check("illegal_car_pulses", n_ent + n_ext, 0);

    // Timeout while parked in ENT_A.
    clear_counts();
    mark = step_idx + 1;
    hold(1'b1, 1'b0, 20);
    check("timeout_error", n_err, 1);
    check("timeout_when", last_err - mark, LAT + int'(T));
    hold(1'b0, 1'b0, 10);
    check("timeout_car_pulses", n_ent + n_ext, 0);
    check("timeout_busy_end", int'(busy), 0);

    // Reset while in ENT_B.
    clear_counts();
    hold(1'b1, 1'b0, 5); hold(1'b1, 1'b1, 5); hold(1'b0, 1'b1, 5);
    step(1'b0, 1'b1, 1'b1);
    check("midreset_outputs", int'({enter, exit_o, error_o, busy}), 0);
    step(1'b0, 1'b0, 1'b1);
    hold(1'b0, 1'b0, 10);
    check("midreset_pulses", n_ent + n_ext + n_err, 0);

`ifdef CAR_DET_DEBOUNCE_EN
    // Short glitch on sensor_a is filtered out entirely.
    clear_counts();
    hold(1'b1, 1'b0, 2); hold(1'b0, 1'b0, 12);
    check("glitch_busy_cycles", n_busy, 0);
`endif

    // Randomized traffic: legal cars, noise, occasional reset.
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: random_car();
        5: step(1'b0, 1'b0, 1'b1);
        6: hold(1'b0, 1'b0, int'($urandom_range(1, 4)));
        default: hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(1, 12)));
      endcase
    end
    hold(1'b0, 1'b0, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
